l2_prefetch_coverage_rolling_sampler: RTL

Rolling-window accumulator feeding the L2 prefetch-coverage DPI writer stage. Every cycle it sums per-cycle y-axis events (useful prefetch hits) and x-axis events (demand accesses). When the x-axis sum reaches a fixed granularity, or on an explicit flush, it emits one registered data point (y sum, x sum, cycle stamp) as a single-cycle `en` pulse. The outputs connect directly to the writer's `en`, `data_yAxisPt`, `data_xAxisPt` and `stamp` inputs.

---
 rtl/l2_prefetch_coverage_rolling_sampler.sv | 44 ++++
 1 files changed

// File: rtl/l2_prefetch_coverage_rolling_sampler.sv
// l2_prefetch_coverage_rolling_sampler: rolling y/x event accumulator emitting one stamped data point per closed window
module l2_prefetch_coverage_rolling_sampler #(
  parameter logic [63:0] GRANULARITY = 64'd1000,
  parameter int INCR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INCR_W-1:0] yIncr,
  input  logic [INCR_W-1:0] xIncr,
  input  logic              flush,
  output logic              en,
  output logic [63:0]       data_yAxisPt,
  output logic [63:0]       data_xAxisPt,
  output logic [63:0]       stamp
);
  logic [63:0] cyc_cnt, y_acc, x_acc, y_next, x_next;
  logic close;
  // a flush of an empty window is a no-op so the writer never sees zero points
  always_comb begin
    y_next = y_acc + 64'(yIncr);
    x_next = x_acc + 64'(xIncr);
    close  = (x_next >= GRANULARITY) || (flush && (x_next != '0 || y_next != '0));
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cyc_cnt      <= '0;
      y_acc        <= '0;
      x_acc        <= '0;
      en           <= 1'b0;
      data_yAxisPt <= '0;
      data_xAxisPt <= '0;
      stamp        <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 64'd1;
      en      <= close;
      y_acc   <= close ? '0 : y_next;
      x_acc   <= close ? '0 : x_next;
      if (close) begin
        data_yAxisPt <= y_next;
        data_xAxisPt <= x_next;
        stamp        <= cyc_cnt;
      end
    end
endmodule
